// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared types and constants for the five-stage pipeline:
//               sequencer state encoding and the load result-source code.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    // Sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } ctrl_state_t;

    // Result-source code of a load; also used by decode and writeback.
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Flags a load in execute whose destination is read by the
//               instruction in decode. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic [4:0] D_rs1,
    input  logic [4:0] D_rs2,
    input  logic       D_uses_rs1,
    input  logic       D_uses_rs2,
    input  logic [4:0] E_rd,
    input  logic       E_RegWrite,
    input  logic [1:0] E_result_src,
    output logic       hazard
);

    logic is_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real dependency, so a load targeting it never stalls.
    always_comb begin
        is_load = E_RegWrite && (E_result_src == RESULT_SRC_LOAD) && (E_rd != 5'd0);
        rs1_hit = D_uses_rs1 && (D_rs1 == E_rd);
        rs2_hit = D_uses_rs2 && (D_rs2 == E_rd);
        hazard  = is_load && (rs1_hit || rs2_hit);
    end

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Central sequencer of the five-stage pipeline. Produces PC and
//               pipeline-register enables/flushes (boot, start, load-use
//               stall, redirect flush, memory freeze, drain-to-halt) and keeps
//               cycle/stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  trigger,
    input  logic [4:0]            D_rs1,
    input  logic [4:0]            D_rs2,
    input  logic                  D_uses_rs1,
    input  logic                  D_uses_rs2,
    input  logic                  D_halt,
    input  logic [4:0]            E_rd,
    input  logic                  E_RegWrite,
    input  logic [1:0]            E_result_src,
    input  logic                  E_PCSrc,
    input  logic                  M_mem_busy,
    output logic                  F_en,
    output logic                  FD_en,
    output logic                  DE_en,
    output logic                  EM_en,
    output logic                  MW_en,
    output logic                  FD_flush,
    output logic                  DE_flush,
    output logic                  running,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] cycle_cnt,
    output logic [DATA_WIDTH-1:0] stall_cnt,
    output logic [DATA_WIDTH-1:0] flush_cnt
);

    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] CNT_ONE   = DATA_WIDTH'(1);
    localparam logic [DRAIN_W-1:0]    DRAIN_ONE = DRAIN_W'(1);
    localparam logic [DRAIN_W-1:0]    DRAIN_LD  = DRAIN_W'(DRAIN_CYCLES);

    ctrl_state_t           state_q, state_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic [DATA_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [DATA_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [DATA_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                  running_q, running_d;
    logic                  halted_q, halted_d;

    logic load_use;
    logic ev_stall;
    logic ev_flush;
    logic active;

    load_use_detect u_load_use_detect (
        .D_rs1        (D_rs1),
        .D_rs2        (D_rs2),
        .D_uses_rs1   (D_uses_rs1),
        .D_uses_rs2   (D_uses_rs2),
        .E_rd         (E_rd),
        .E_RegWrite   (E_RegWrite),
        .E_result_src (E_result_src),
        .hazard       (load_use)
    );

    // Enables, flushes, next state and performance events from state and inputs.
    always_comb begin
        F_en     = 1'b0;
        FD_en    = 1'b0;
        DE_en    = 1'b0;
        EM_en    = 1'b0;
        MW_en    = 1'b0;
        FD_flush = 1'b0;
        DE_flush = 1'b0;
        ev_stall = 1'b0;
        ev_flush = 1'b0;
        active   = 1'b0;
        state_d  = state_q;
        drain_d  = drain_q;

        case (state_q)
            ST_BOOT: begin
                FD_flush = 1'b1;
                DE_flush = 1'b1;
                state_d  = ST_IDLE;
            end

            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                active = 1'b1;
                if (M_mem_busy) begin
                    // Whole-pipeline freeze; a pending redirect is re-presented.
                    ev_stall = 1'b1;
                end else if (E_PCSrc) begin
                    F_en     = 1'b1;
                    FD_en    = 1'b1;
                    DE_en    = 1'b1;
                    EM_en    = 1'b1;
                    MW_en    = 1'b1;
                    FD_flush = 1'b1;
                    DE_flush = 1'b1;
                    ev_flush = 1'b1;
                end else if (load_use) begin
                    // Hold F and D, inject a bubble into E.
                    DE_en    = 1'b1;
                    EM_en    = 1'b1;
                    MW_en    = 1'b1;
                    DE_flush = 1'b1;
                    ev_stall = 1'b1;
                end else begin
                    F_en  = 1'b1;
                    FD_en = 1'b1;
                    DE_en = 1'b1;
                    EM_en = 1'b1;
                    MW_en = 1'b1;
                    // Halt only counts when it actually advances out of D.
                    if (D_halt) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_d = ST_HALTED;
                        end else begin
                            state_d = ST_DRAIN;
                            drain_d = DRAIN_LD;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                active = 1'b1;
                if (M_mem_busy) begin
                    ev_stall = 1'b1;
                end else begin
                    // Fetch stopped; bubbles fill F_D while older work retires.
                    FD_en    = 1'b1;
                    FD_flush = 1'b1;
                    DE_en    = 1'b1;
                    EM_en    = 1'b1;
                    MW_en    = 1'b1;
                    drain_d  = drain_q - DRAIN_ONE;
                    if (drain_q <= DRAIN_ONE) begin
                        state_d = ST_HALTED;
                    end
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase

        cycle_cnt_d = active   ? cycle_cnt_q + CNT_ONE : cycle_cnt_q;
        stall_cnt_d = ev_stall ? stall_cnt_q + CNT_ONE : stall_cnt_q;
        flush_cnt_d = ev_flush ? flush_cnt_q + CNT_ONE : flush_cnt_q;
        running_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        halted_d    = (state_d == ST_HALTED);
    end

    // State, drain counter, status flags and performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_BOOT;
            drain_q     <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
        end
    end

    assign running   = running_q;
    assign halted    = halted_q;
    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl: directed scenarios
//               followed by randomized traffic compared against a
//               behavioural model of the sequencer rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int DATA_WIDTH   = 32;
    localparam int DRAIN_CYCLES = 3;

    // Model phases.
    localparam int P_BOOT   = 0;
    localparam int P_IDLE   = 1;
    localparam int P_RUN    = 2;
    localparam int P_DRAIN  = 3;
    localparam int P_HALTED = 4;

    // Event kinds produced by the model for one cycle.
    localparam int K_NONE  = 0;
    localparam int K_STALL = 1;
    localparam int K_FLUSH = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  trigger;
    logic [4:0]            D_rs1, D_rs2, E_rd;
    logic                  D_uses_rs1, D_uses_rs2, D_halt;
    logic                  E_RegWrite, E_PCSrc, M_mem_busy;
    logic [1:0]            E_result_src;
    logic                  F_en, FD_en, DE_en, EM_en, MW_en, FD_flush, DE_flush;
    logic                  running, halted;
    logic [DATA_WIDTH-1:0] cycle_cnt, stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    int                    m_phase;
    int                    m_left;
    logic [DATA_WIDTH-1:0] m_cyc, m_stall, m_flush;

    pipeline_ctrl #(
        .DATA_WIDTH   (DATA_WIDTH),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst_n),
        .trigger      (trigger),
        .D_rs1        (D_rs1),
        .D_rs2        (D_rs2),
        .D_uses_rs1   (D_uses_rs1),
        .D_uses_rs2   (D_uses_rs2),
        .D_halt       (D_halt),
        .E_rd         (E_rd),
        .E_RegWrite   (E_RegWrite),
        .E_result_src (E_result_src),
        .E_PCSrc      (E_PCSrc),
        .M_mem_busy   (M_mem_busy),
        .F_en         (F_en),
        .FD_en        (FD_en),
        .DE_en        (DE_en),
        .EM_en        (EM_en),
        .MW_en        (MW_en),
        .FD_flush     (FD_flush),
        .DE_flush     (DE_flush),
        .running      (running),
        .halted       (halted),
        .cycle_cnt    (cycle_cnt),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_BOOT;
        m_left  = 0;
        m_cyc   = '0;
        m_stall = '0;
        m_flush = '0;
    endtask

    // Expected {F,FD,DE,EM,MW,FD_flush,DE_flush} and event kind this cycle.
    task automatic model_out(output logic [6:0] ev, output int kind);
        logic lu;
        lu = E_RegWrite && (E_result_src == 2'b01) && (E_rd != 0) &&
             ((D_uses_rs1 && D_rs1 == E_rd) || (D_uses_rs2 && D_rs2 == E_rd));
        ev   = 7'b0000000;
        kind = K_NONE;
        if (m_phase == P_BOOT) begin
            ev = 7'b0000011;
        end else if (m_phase == P_RUN) begin
            if (M_mem_busy)   kind = K_STALL;
            else if (E_PCSrc) begin ev = 7'b1111111; kind = K_FLUSH; end
            else if (lu)      begin ev = 7'b0011101; kind = K_STALL; end
            else              ev = 7'b1111100;
        end else if (m_phase == P_DRAIN) begin
            if (M_mem_busy) kind = K_STALL;
            else            ev = 7'b0111110;
        end
    endtask

    task automatic model_update(input int kind);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_phase == P_RUN || m_phase == P_DRAIN) m_cyc = m_cyc + 1;
            if (kind == K_STALL) m_stall = m_stall + 1;
            if (kind == K_FLUSH) m_flush = m_flush + 1;
            case (m_phase)
                P_BOOT: m_phase = P_IDLE;
                P_IDLE: if (trigger) m_phase = P_RUN;
                P_RUN: begin
                    if (kind == K_NONE && D_halt) begin
                        m_phase = P_DRAIN;
                        m_left  = DRAIN_CYCLES;
                    end
                end
                P_DRAIN: begin
                    if (!M_mem_busy) begin
                        m_left = m_left - 1;
                        if (m_left == 0) m_phase = P_HALTED;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Called just after a falling edge with inputs set: compare, clock, advance.
    task automatic step(input string tag);
        logic [6:0] ev;
        int         kind;
        #1;
        model_out(ev, kind);
        check_val({tag, ".en"}, {57'd0, F_en, FD_en, DE_en, EM_en, MW_en, FD_flush, DE_flush}, {57'd0, ev});
        check_val({tag, ".running"}, {63'd0, running}, {63'd0, (m_phase == P_RUN || m_phase == P_DRAIN)});
        check_val({tag, ".halted"}, {63'd0, halted}, {63'd0, (m_phase == P_HALTED)});
        check_val({tag, ".cycle_cnt"}, {32'd0, cycle_cnt}, {32'd0, m_cyc});
        check_val({tag, ".stall_cnt"}, {32'd0, stall_cnt}, {32'd0, m_stall});
        check_val({tag, ".flush_cnt"}, {32'd0, flush_cnt}, {32'd0, m_flush});
        @(posedge clk);
        model_update(kind);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        trigger      = 1'b0;
        D_rs1        = 5'd0;
        D_rs2        = 5'd0;
        D_uses_rs1   = 1'b0;
        D_uses_rs2   = 1'b0;
        D_halt       = 1'b0;
        E_rd         = 5'd0;
        E_RegWrite   = 1'b0;
        E_result_src = 2'b00;
        E_PCSrc      = 1'b0;
        M_mem_busy   = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
    endtask

    // Reset, boot cycle, one trigger cycle: next cycle is the first RUN cycle.
    task automatic boot_and_start();
        clear_inputs();
        apply_reset();
        step("rst");
        rst_n = 1'b1;
        step("boot");
        trigger = 1'b1;
        step("trig");
        trigger = 1'b0;
    endtask

    task automatic randomize_inputs();
        trigger      = ($urandom_range(0, 1) == 1);
        D_rs1        = 5'($urandom_range(0, 3));
        D_rs2        = 5'($urandom_range(0, 3));
        D_uses_rs1   = ($urandom_range(0, 1) == 1);
        D_uses_rs2   = ($urandom_range(0, 1) == 1);
        D_halt       = ($urandom_range(0, 99) < 4);
        E_rd         = 5'($urandom_range(0, 3));
        E_RegWrite   = ($urandom_range(0, 99) < 70);
        E_result_src = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3));
        E_PCSrc      = ($urandom_range(0, 99) < 12);
        M_mem_busy   = ($urandom_range(0, 99) < 15);
    endtask

    initial begin
        clear_inputs();
        apply_reset();
        @(negedge clk);

        // Reset values, no clock edge needed.
        #1;
        check_val("reset.en", {57'd0, F_en, FD_en, DE_en, EM_en, MW_en, FD_flush, DE_flush}, 64'h03);
        check_val("reset.running", {63'd0, running}, 64'd0);
        check_val("reset.cycle_cnt", {32'd0, cycle_cnt}, 64'd0);
        step("rst_hold");

        // Boot then five idle cycles with trigger low.
        rst_n = 1'b1;
        step("boot");
        for (int i = 0; i < 5; i++) step("idle");
        trigger = 1'b1;
        step("idle_trig");
        trigger = 1'b0;
        #1;
        check_val("first_run.running", {63'd0, running}, 64'd1);
        step("run1");
        #1;
        check_val("first_run.cycle_cnt", {32'd0, cycle_cnt}, 64'd1);

        // Load-use on rs1.
        E_rd = 5'd5; E_RegWrite = 1'b1; E_result_src = 2'b01;
        D_rs1 = 5'd5; D_uses_rs1 = 1'b1;
        step("lu");
        clear_inputs();
        step("lu_after");
        #1;
        check_val("lu.stall_cnt", {32'd0, stall_cnt}, 64'd1);

        // Load targeting x0 never stalls.
        E_rd = 5'd0; E_RegWrite = 1'b1; E_result_src = 2'b01;
        D_rs1 = 5'd0; D_uses_rs1 = 1'b1;
        step("lu_x0");
        #1;
        check_val("lu_x0.stall_cnt", {32'd0, stall_cnt}, 64'd1);

        // Redirect together with a load-use: flush wins, no stall counted.
        E_rd = 5'd7; E_RegWrite = 1'b1; E_result_src = 2'b01;
        D_rs2 = 5'd7; D_uses_rs2 = 1'b1; E_PCSrc = 1'b1;
        step("redir_lu");
        clear_inputs();
        #1;
        check_val("redir.flush_cnt", {32'd0, flush_cnt}, 64'd1);
        check_val("redir.stall_cnt", {32'd0, stall_cnt}, 64'd1);

        // Memory freeze over a pending redirect, then the flush on cycle 4.
        E_PCSrc = 1'b1; M_mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) step("freeze");
        M_mem_busy = 1'b0;
        step("freeze_redir");
        E_PCSrc = 1'b0;
        #1;
        check_val("freeze.stall_cnt", {32'd0, stall_cnt}, 64'd4);
        check_val("freeze.flush_cnt", {32'd0, flush_cnt}, 64'd2);

        // Halt in a clean cycle, three drain cycles, then halted.
        D_halt = 1'b1;
        step("halt");
        D_halt = 1'b0;
        for (int i = 0; i < 3; i++) step("drain");
        #1;
        check_val("halt.halted", {63'd0, halted}, 64'd1);
        trigger = 1'b1;
        step("halted_trig");
        step("halted_trig2");
        trigger = 1'b0;

        // Busy inside DRAIN stretches it to four cycles.
        boot_and_start();
        D_halt = 1'b1;
        step("halt2");
        D_halt = 1'b0;
        step("drain2_a");
        M_mem_busy = 1'b1;
        step("drain2_busy");
        M_mem_busy = 1'b0;
        step("drain2_b");
        #1;
        check_val("drain2.not_halted", {63'd0, halted}, 64'd0);
        step("drain2_c");
        #1;
        check_val("drain2.halted", {63'd0, halted}, 64'd1);

        // Reset asserted mid-DRAIN acts without a clock edge.
        boot_and_start();
        D_halt = 1'b1;
        step("halt3");
        D_halt = 1'b0;
        step("drain3");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_drain.en", {57'd0, F_en, FD_en, DE_en, EM_en, MW_en, FD_flush, DE_flush}, 64'h03);
        check_val("rst_drain.running", {63'd0, running}, 64'd0);
        check_val("rst_drain.cycle_cnt", {32'd0, cycle_cnt}, 64'd0);
        model_reset();
        @(negedge clk);
        step("rst_drain_hold");
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            if ((m_phase == P_HALTED && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                apply_reset();
                step("rnd_rst");
                rst_n = 1'b1;
            end else begin
                randomize_inputs();
                step("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipeline_ctrl
`default_nettype wire
